i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/eq_pkg.sv | 9 +
 rtl/sync_2ff.sv | 22 ++
 rtl/i2s_rx.sv | 151 +++++++++++++++
 tb/tb_i2s_rx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and constants for the I2S receiver: sample type, FSM states, default slot length.
package eq_pkg;
   localparam int I2S_WD_OUT    = 24;
   localparam int I2S_SLOT_BITS = 32;

   typedef logic signed [I2S_WD_OUT-1:0] sample_t;

   typedef enum logic [1:0] {IDLE, SKIP, SHIFT, PAD} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/i2s_rx.sv
// I2S stereo receiver: oversamples BCLK in the clk domain and delivers left/right sample pairs.
// Optional error counter output err_count is built when I2S_RX_ERR_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first lrck 1->0 boundary
// SKIP  | boundary bit seen, discarding the one-bit I2S delay
// SHIFT | capturing data bits MSB first
// PAD   | word complete, ignoring bits until the next boundary
module i2s_rx
   import eq_pkg::*;
#(
   parameter int WD_OUT    = 24,
   parameter int SLOT_BITS = I2S_SLOT_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i2s_bclk,
   input  logic                     i2s_lrck,
   input  logic                     i2s_sdata,
   output logic signed [WD_OUT-1:0] left_out,
   output logic signed [WD_OUT-1:0] right_out,
   output logic                     sample_valid,
   output logic                     frame_err
`ifdef I2S_RX_ERR_CNT_EN
   ,
   output logic [7:0]               err_count
`endif
);
   localparam int CNT_W = $clog2(SLOT_BITS);

   logic w_bclk, w_lrck, w_sdata;
   sync_2ff u_sync_bclk  (.clk(clk), .reset(reset), .i_d(i2s_bclk),  .o_q(w_bclk));
   sync_2ff u_sync_lrck  (.clk(clk), .reset(reset), .i_d(i2s_lrck),  .o_q(w_lrck));
   sync_2ff u_sync_sdata (.clk(clk), .reset(reset), .i_d(i2s_sdata), .o_q(w_sdata));

   rx_state_t          r_state, w_state_nxt;
   logic               r_bclk_prev, r_lrck_prev, r_chan, r_left_ok, r_publish;
   logic [CNT_W-1:0]   r_cnt;
   logic [WD_OUT-2:0]  r_shift;
   logic [WD_OUT-1:0]  r_hold_l, r_hold_r;
   logic               w_rise, w_bound, w_start;
   logic               w_load, w_shift, w_done, w_err, w_new_slot;
   logic [WD_OUT-1:0]  w_word;

   assign w_rise  = w_bclk & ~r_bclk_prev;
   assign w_bound = w_rise & (w_lrck != r_lrck_prev);
   assign w_start = w_bound & r_lrck_prev & ~w_lrck;
   assign w_word  = {r_shift, w_sdata};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_new_slot  = 1'b0;
      if (w_rise) begin
         case (r_state)
            IDLE: if (w_start) begin
               w_state_nxt = SKIP;
               w_new_slot  = 1'b1;
            end
            // first bit after the delay bit is the MSB, so it is loaded on leaving SKIP
            SKIP: if (w_bound) begin
               w_err      = 1'b1;
               w_new_slot = 1'b1;
            end else begin
               w_load      = 1'b1;
               w_state_nxt = SHIFT;
            end
            SHIFT: if (w_bound) begin
               w_err       = 1'b1;
               w_new_slot  = 1'b1;
               w_state_nxt = SKIP;
            end else if (r_cnt == CNT_W'(WD_OUT-2)) begin
               w_done      = 1'b1;
               w_state_nxt = PAD;
            end else begin
               w_shift = 1'b1;
            end
            PAD: if (w_bound) begin
               w_state_nxt = SKIP;
               w_new_slot  = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bclk_prev  <= 1'b0;
         r_lrck_prev  <= 1'b0;
         r_chan       <= 1'b0;
         r_left_ok    <= 1'b0;
         r_publish    <= 1'b0;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_hold_l     <= '0;
         r_hold_r     <= '0;
         left_out     <= '0;
         right_out    <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         r_bclk_prev <= w_bclk;
         if (w_rise) r_lrck_prev <= w_lrck;
         if (w_new_slot) r_chan <= w_lrck;
         if (w_load) begin
            r_shift <= {{(WD_OUT-2){1'b0}}, w_sdata};
            r_cnt   <= '0;
         end
         if (w_shift) begin
            r_shift <= {r_shift[WD_OUT-3:0], w_sdata};
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_err) r_left_ok <= 1'b0;
         if (w_done) begin
            if (!r_chan) begin
               r_hold_l  <= w_word;
               r_left_ok <= 1'b1;
            end else begin
               if (r_left_ok) r_hold_r <= w_word;
               r_left_ok <= 1'b0;
            end
         end
         // right word without a good left partner is dropped
         r_publish    <= w_done & r_chan & r_left_ok;
         sample_valid <= r_publish;
         if (r_publish) begin
            left_out  <= r_hold_l;
            right_out <= r_hold_r;
         end
         frame_err <= w_err;
      end
   end

`ifdef I2S_RX_ERR_CNT_EN
   logic [7:0] r_err_cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                            r_err_cnt <= '0;
      else if (frame_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
   end
   assign err_count = r_err_cnt;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: directed frames push expected pairs, a monitor checks each sample_valid.
module tb_i2s_rx;
   import eq_pkg::*;

   logic clk = 1'b0, reset = 1'b0;
   logic i2s_bclk = 1'b0, i2s_lrck = 1'b1, i2s_sdata = 1'b0;
   logic signed [23:0] left_out, right_out;
   logic sample_valid, frame_err;
`ifdef I2S_RX_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   i2s_rx #(.WD_OUT(24), .SLOT_BITS(32)) dut (
      .clk(clk), .reset(reset),
      .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
      .left_out(left_out), .right_out(right_out),
      .sample_valid(sample_valid), .frame_err(frame_err)
`ifdef I2S_RX_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {sample_t l; sample_t r;} frame_t;
   frame_t q_exp[$];
   int n_tests = 0, n_fail = 0, n_valid = 0, n_err = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (sample_valid === 1'b1) begin
         n_valid++;
         if (q_exp.size() == 0) check("spurious_valid", 32'd1, 32'd0);
         else begin
            frame_t f;
            f = q_exp.pop_front();
            check("sb_left",  {8'h0, left_out},  {8'h0, f.l});
            check("sb_right", {8'h0, right_out}, {8'h0, f.r});
         end
      end
      if (frame_err === 1'b1) n_err++;
   end

   // bit 0 of a slot is the delay bit; data occupies bits 1..24, the rest is padding
   task automatic send_slot(input logic lr, input logic [23:0] word, input int len, input logic pad);
      for (int i = 0; i < len; i++) begin
         i2s_bclk = 1'b0;
         i2s_lrck = lr;
         if (i == 0 || i > 24) i2s_sdata = pad;
         else                  i2s_sdata = word[24-i];
         #40 i2s_bclk = 1'b1;
         #40;
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int len, input logic pad);
      frame_t f;
      f.l = l;
      f.r = r;
      q_exp.push_back(f);
      send_slot(1'b0, l, len, pad);
      send_slot(1'b1, r, len, pad);
   endtask

   task automatic check_out(string name, input logic [23:0] l, input logic [23:0] r);
      check({name, "_left"},  {8'h0, left_out},  {8'h0, l});
      check({name, "_right"}, {8'h0, right_out}, {8'h0, r});
   endtask

   initial begin
      #1 reset = 1'b1;
      #22;
      check("rst_left",  {8'h0, left_out},  32'h0);
      check("rst_right", {8'h0, right_out}, 32'h0);
      check("rst_valid", {31'h0, sample_valid}, 32'h0);
      check("rst_err",   {31'h0, frame_err},    32'h0);
      @(negedge clk) reset = 1'b0;

      // stream joins mid right slot
      send_slot(1'b1, 24'hA5A5A5, 12, 1'b1);
      check("no_out_before_boundary", n_valid, 32'd0);

      send_frame(24'h123456, 24'hFEDCBA, 32, 1'b0);
      check("a_count", n_valid, 32'd1);
      check_out("a", 24'h123456, 24'hFEDCBA);
      check("a_right_neg", {31'h0, right_out[23]}, 32'd1);

      send_frame(24'h7FFFFF, 24'h800000, 64, 1'b1);
      check("b_count", n_valid, 32'd2);
      check_out("b", 24'h7FFFFF, 24'h800000);

      // right slot cut to 20 BCLKs; error appears at the next boundary
      send_slot(1'b0, 24'hABCDEF, 32, 1'b0);
      send_slot(1'b1, 24'h13579B, 20, 1'b0);
      q_exp.push_back(frame_t'({24'h000001, 24'hFFFFFF}));
      send_slot(1'b0, 24'h000001, 32, 1'b0);
      check("trunc_r_err", n_err, 32'd1);
      check("trunc_r_count", n_valid, 32'd2);
      check_out("trunc_r_hold", 24'h7FFFFF, 24'h800000);
      send_slot(1'b1, 24'hFFFFFF, 32, 1'b0);
      check("c_count", n_valid, 32'd3);

      // truncated left makes the following right word orphaned
      send_slot(1'b0, 24'h111111, 20, 1'b0);
      send_slot(1'b1, 24'h555555, 32, 1'b0);
      check("trunc_l_err", n_err, 32'd2);
      check("trunc_l_count", n_valid, 32'd3);
      check_out("trunc_l_hold", 24'h000001, 24'hFFFFFF);
      send_frame(24'h654321, 24'hAAAAAA, 32, 1'b0);
      check("d_count", n_valid, 32'd4);

      // reset in the middle of a left word
      send_slot(1'b0, 24'h2468AC, 10, 1'b0);
      i2s_bclk = 1'b0;
      @(negedge clk) reset = 1'b1;
      #2;
      check_out("midrst", 24'h0, 24'h0);
      check("midrst_valid", {31'h0, sample_valid}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      send_slot(1'b0, 24'h0, 22, 1'b0);
      send_slot(1'b1, 24'h999999, 32, 1'b0);
      check("post_rst_no_valid", n_valid, 32'd4);
      check_out("post_rst_zero", 24'h0, 24'h0);
      send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 1'b0);
      check("e_count", n_valid, 32'd5);
      check_out("e", 24'h0F0F0F, 24'hF0F0F0);

`ifdef I2S_RX_ERR_CNT_EN
      for (int k = 0; k < 300; k++) send_slot(k[0], 24'hFFFFFF, 10, 1'b0);
      send_slot(1'b0, 24'h0, 2, 1'b0);
      repeat (10) @(negedge clk);
      check("err_count_sat", {24'h0, err_count}, 32'd255);
`endif

      repeat (20) @(negedge clk);
      check("queue_drained", q_exp.size(), 32'd0);
      check("total_valid", n_valid, 32'd5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
